// File: rtl/timer_bank.sv
// timer_bank: NCH match timers sharing one prescaler, each with a one-cycle match pulse and sticky irq.
// Define TIMER_CASCADE_EN to let channel i>0 step on channel i-1's match pulse.
module timer_chan #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         tick,
   input  logic         prev,
   input  logic         wr,
   input  logic [N-1:0] wr_match,
   input  logic         wr_enable,
   input  logic         wr_oneshot,
   input  logic         wr_cascade,
   input  logic         ack,
   output logic [N-1:0] count,
   output logic         signal,
   output logic         irq
);
   logic [N-1:0] match;
   logic         enable, oneshot, step, hit;

`ifdef TIMER_CASCADE_EN
   logic cascade;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) cascade <= 1'b0;
      else if (wr)  cascade <= wr_cascade;
   assign step = cascade ? prev : tick;
`else
   logic cascade_unused;
   assign cascade_unused = wr_cascade ^ prev;
   assign step = tick;
`endif

   // A write on the same edge overrides any match, so hit is masked by wr.
   assign hit = enable && step && (count == match) && !wr;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count   <= '0;
         match   <= '0;
         enable  <= 1'b0;
         oneshot <= 1'b0;
         signal  <= 1'b0;
         irq     <= 1'b0;
      end else begin
         signal <= hit;
         irq    <= (irq & ~ack) | hit;
         if (wr) begin
            match   <= wr_match;
            enable  <= wr_enable;
            oneshot <= wr_oneshot;
            count   <= '0;
         end else if (enable && step) begin
            if (count == match) begin
               count <= '0;
               if (oneshot) enable <= 1'b0;
            end else begin
               count <= count + N'(1);
            end
         end
      end
   end
endmodule

module timer_bank #(
   parameter int N   = 32,
   parameter int NCH = 4,
   parameter int P   = 8,
   parameter int CW  = 2
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic [P-1:0]   prescale,
   input  logic           wr_en,
   input  logic [CW-1:0]  wr_sel,
   input  logic [N-1:0]   wr_match,
   input  logic           wr_enable,
   input  logic           wr_oneshot,
   input  logic           wr_cascade,
   input  logic [NCH-1:0] irq_ack,
   input  logic [CW-1:0]  rd_sel,
   output logic [N-1:0]   rd_count,
   output logic [NCH-1:0] signal,
   output logic [NCH-1:0] irq
);
   logic [P-1:0]            pre_cnt;
   logic                    tick;
   logic [NCH-1:0][N-1:0]   count;

   // Equality compare: lowering prescale below pre_cnt lets it wrap through 2**P.
   assign tick = (pre_cnt == prescale);

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) pre_cnt <= '0;
      else          pre_cnt <= tick ? '0 : pre_cnt + P'(1);

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      logic prev;
      if (i == 0) begin : g_first
         assign prev = tick;
      end else begin : g_rest
         assign prev = signal[i-1];
      end
      timer_chan #(.N(N)) u_chan (
         .clk        (clk),
         .reset_n    (reset_n),
         .tick       (tick),
         .prev       (prev),
         .wr         (wr_en && (wr_sel == CW'(i))),
         .wr_match   (wr_match),
         .wr_enable  (wr_enable),
         .wr_oneshot (wr_oneshot),
         .wr_cascade (wr_cascade),
         .ack        (irq_ack[i]),
         .count      (count[i]),
         .signal     (signal[i]),
         .irq        (irq[i])
      );
   end

   always_comb begin
      rd_count = '0;
      for (int i = 0; i < NCH; i++)
         if (rd_sel == CW'(i)) rd_count = count[i];
   end
endmodule

// File: tb/tb_timer_bank.sv
// Bench for timer_bank: directed scenarios plus random traffic against a tick-counting reference model.
module tb_timer_bank;
   logic        clk = 1'b0;
   logic        reset_n;
   logic [7:0]  prescale;
   logic        wr_en;
   logic [1:0]  wr_sel;
   logic [31:0] wr_match;
   logic        wr_enable, wr_oneshot, wr_cascade;
   logic [3:0]  irq_ack;
   logic [1:0]  rd_sel;
   logic [31:0] rd_count;
   logic [3:0]  signal, irq;

   int checks = 0;
   int errors = 0;

   // Reference: count is simply (ticks seen since the last write) mod (match+1).
   longint      m_ticks [4];
   logic [31:0] m_match [4];
   bit          m_en [4], m_os [4], m_cas [4], m_irq [4], m_sig [4];
   int          m_pre;

   timer_bank dut (
      .clk(clk), .reset_n(reset_n), .prescale(prescale), .wr_en(wr_en), .wr_sel(wr_sel),
      .wr_match(wr_match), .wr_enable(wr_enable), .wr_oneshot(wr_oneshot),
      .wr_cascade(wr_cascade), .irq_ack(irq_ack), .rd_sel(rd_sel), .rd_count(rd_count),
      .signal(signal), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_pre = 0;
      for (int c = 0; c < 4; c++) begin
         m_ticks[c] = 0; m_match[c] = 0; m_en[c] = 0; m_os[c] = 0;
         m_cas[c] = 0; m_irq[c] = 0; m_sig[c] = 0;
      end
   endtask

   task automatic cyc();
      bit tk, stp;
      bit old_sig [4];
      @(posedge clk);
      if (!reset_n) begin
         model_reset();
      end else begin
         tk = (m_pre == int'(prescale));
         m_pre = tk ? 0 : (m_pre + 1) % 256;
         for (int c = 0; c < 4; c++) old_sig[c] = m_sig[c];
         for (int c = 0; c < 4; c++) begin
            m_sig[c] = 0;
            stp = tk;
`ifdef TIMER_CASCADE_EN
            if (c > 0 && m_cas[c]) stp = old_sig[c-1];
`endif
            if (wr_en && int'(wr_sel) == c) begin
               m_match[c] = wr_match; m_en[c] = wr_enable; m_os[c] = wr_oneshot;
               m_cas[c] = wr_cascade; m_ticks[c] = 0;
            end else if (m_en[c] && stp) begin
               m_ticks[c]++;
               if (m_ticks[c] % (longint'(m_match[c]) + 1) == 0) begin
                  m_sig[c] = 1;
                  if (m_os[c]) begin m_en[c] = 0; m_ticks[c] = 0; end
               end
            end
            m_irq[c] = (m_irq[c] & !irq_ack[c]) | m_sig[c];
         end
      end
      #1;
      for (int c = 0; c < 4; c++) begin
         chk($sformatf("signal%0d", c), 32'(signal[c]), 32'(m_sig[c]));
         chk($sformatf("irq%0d", c), 32'(irq[c]), 32'(m_irq[c]));
      end
      chk("rd_count", rd_count,
          32'(m_ticks[rd_sel] % (longint'(m_match[rd_sel]) + 1)));
   endtask

   task automatic wr(input int c, input int m, input bit en, input bit os, input bit cas);
      logic [31:0] cv;
      cv = c;
      wr_en = 1; wr_sel = cv[1:0]; wr_match = m; wr_enable = en; wr_oneshot = os; wr_cascade = cas;
      cyc();
      wr_en = 0; wr_cascade = 0;
   endtask

   initial begin
      int first, pulses, t1, t2, k;
      logic [31:0] r;
      reset_n = 0; prescale = 0; wr_en = 0; wr_sel = 0; wr_match = 0; wr_enable = 0;
      wr_oneshot = 0; wr_cascade = 0; irq_ack = 0; rd_sel = 0;
      model_reset();
      #1;
      chk("rst_signal", 32'(signal), 0);
      chk("rst_irq", 32'(irq), 0);
      chk("rst_count", rd_count, 0);
      cyc(); cyc();
      reset_n = 1;

      // ch0 periodic, match=3, prescale=0: first pulse 4 cycles after the write
      wr(0, 3, 1, 0, 0);
      first = -1;
      for (int i = 1; i <= 12; i++) begin
         cyc();
         if (signal[0] && first < 0) first = i;
      end
      chk("first_pulse0", first, 4);
      chk("irq0_set", 32'(irq[0]), 1);

      // prescale=2, ch1 match=1 periodic
      prescale = 2; rd_sel = 1;
      wr(1, 1, 1, 0, 0);
      for (int i = 0; i < 20; i++) cyc();

      // ch2 one-shot: a single pulse, then idle at count 0
      rd_sel = 2;
      wr(2, 5, 1, 1, 0);
      pulses = 0;
      for (int i = 0; i < 60; i++) begin
         cyc();
         pulses += int'(signal[2]);
      end
      chk("oneshot_pulses", pulses, 1);
      chk("oneshot_count", rd_count, 0);

      // Drop prescale to 0 only right after a tick so the prescaler does not wrap
      for (int i = 0; i < 4 && m_pre != 0; i++) cyc();
      prescale = 0;
      irq_ack = 4'b0001;
      cyc();
      irq_ack = 0;
      chk("ack_clear0", 32'(irq[0]), 0);
      wr(0, 3, 1, 0, 0);
      cyc(); cyc(); cyc();
      irq_ack = 4'b0001;
      cyc();
      chk("ack_same_sig", 32'(signal[0]), 1);
      chk("ack_same_irq", 32'(irq[0]), 1);
      cyc();
      chk("ack_late_irq", 32'(irq[0]), 0);
      irq_ack = 0;

      // Rewrite mid-count, then async reset before the next edge
      rd_sel = 0;
      wr(0, 20, 1, 0, 0);
      for (int i = 0; i < 7; i++) cyc();
      chk("count7", rd_count, 7);
      wr(0, 10, 1, 0, 0);
      chk("wr_clears", rd_count, 0);
      for (int i = 0; i < 5; i++) cyc();
      #2 reset_n = 0;
      #1;
      chk("async_signal", 32'(signal), 0);
      chk("async_irq", 32'(irq), 0);
      chk("async_count", rd_count, 0);
      cyc(); cyc();
      reset_n = 1;

      // Cascade setup: ch1 counts ch0 matches only when the feature is built
      rd_sel = 1;
      wr(0, 1, 1, 0, 0);
      wr(1, 2, 1, 0, 1);
      t1 = -1; t2 = -1; k = 0;
      for (int i = 0; i < 30; i++) begin
         cyc();
         k++;
         if (signal[1]) begin
            if (t1 < 0) t1 = k;
            else if (t2 < 0) t2 = k;
         end
      end
`ifdef TIMER_CASCADE_EN
      chk("cascade_period", t2 - t1, 6);
`else
      chk("cascade_period", t2 - t1, 3);
`endif
      wr(1, 2, 1, 0, 0);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         r = $urandom;
         wr_en = (r[2:0] == 0);
         if (wr_en) begin
            wr_sel = 2'($urandom_range(0, 3));
            wr_match = $urandom_range(0, 7);
            wr_enable = ($urandom_range(0, 3) != 0);
            wr_oneshot = r[3];
            wr_cascade = 0;
         end
         irq_ack = (r[6:4] == 0) ? 4'($urandom) : 4'b0;
         rd_sel = 2'($urandom_range(0, 3));
         if (r[15:9] == 0 && m_pre == 0) prescale = 8'($urandom_range(0, 3));
         cyc();
      end
      wr_en = 0; irq_ack = 0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
